// File: rtl/ucore_pkg.sv
// Shared constants and helpers for the ucore operand input stage.
package ucore_pkg;

   localparam int UCORE_MAX_CHANNELS = 8;

   // Bits needed to hold an occupancy of 0..depth inclusive.
   function automatic int count_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/ucore_input_channels_multi_if.sv
// NoC-side token handshake and ucore-side operand handshake of the input stage.
interface ucore_input_channels_multi_if #(
   parameter int N          = 2,
   parameter int DATA_WIDTH = 32
);
   logic [N-1:0]            noc_ivalid;
   logic [N*DATA_WIDTH-1:0] noc_in;
   logic [N-1:0]            noc_oready;
   logic                    ops_valid_o;
   logic [N*DATA_WIDTH-1:0] ops_o;
   logic                    fire_i;

   modport master (
      output noc_ivalid, noc_in, fire_i,
      input  noc_oready, ops_valid_o, ops_o
   );

   modport slave (
      input  noc_ivalid, noc_in, fire_i,
      output noc_oready, ops_valid_o, ops_o
   );
endinterface

// File: rtl/ucore_chan_fifo.sv
// Single-channel token FIFO; any depth, head zeroed when empty, no fall-through.
module ucore_chan_fifo
   import ucore_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 2,
   localparam int CW        = count_width(DEPTH),
   localparam int PW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr_i,
   input  logic                  v_i,
   output logic                  ready_o,
   input  logic [DATA_WIDTH-1:0] data_i,
   output logic                  v_o,
   output logic [DATA_WIDTH-1:0] data_o,
   input  logic                  yumi_i,
   output logic [CW-1:0]         count_o
);
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]         rd_ptr, wr_ptr;
   logic [CW-1:0]         count;
   logic                  push, pop;

   // Explicit compare keeps non-power-of-2 depths wrapping correctly.
   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
      return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
   endfunction

   assign ready_o = (count < CW'(DEPTH));
   assign v_o     = (count != '0);
   assign push    = v_i & ready_o & ~clr_i;
   assign pop     = yumi_i & v_o & ~clr_i;
   assign data_o  = v_o ? mem[rd_ptr] : '0;
   assign count_o = count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (clr_i) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= next_ptr(wr_ptr);
         if (pop)  rd_ptr <= next_ptr(rd_ptr);
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= data_i;
   end
endmodule

// File: rtl/ucore_input_channels_multi.sv
// N-channel operand input stage: per-channel FIFOs, firing rule, sticky heads, error flag.
module ucore_input_channels_multi
   import ucore_pkg::*;
#(
   parameter int DATA_WIDTH         = 32,
   parameter int N                  = 2,
   parameter int INPUT_BUFFER_DEPTH = 2,
   localparam int CW                = count_width(INPUT_BUFFER_DEPTH)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [N-1:0]                  cfg_used_i,
   input  logic [N-1:0]                  cfg_sticky_i,
   input  logic                          flush_i,
   ucore_input_channels_multi_if.slave   bus,
   output logic [N*CW-1:0]               count_o,
   output logic                          protocol_err_o
);
   logic [N-1:0]            head_v;
   logic [N-1:0]            ready_vec;
   logic [N-1:0]            yumi;
   logic [N*DATA_WIDTH-1:0] ops_vec;
   logic                    ops_valid;
   logic                    fire_ok;

   if (N < 1 || N > UCORE_MAX_CHANNELS) begin : g_bad_n
      $error("ucore_input_channels_multi: N out of range");
   end

   for (genvar k = 0; k < N; k++) begin : g_chan
      ucore_chan_fifo #(
         .DATA_WIDTH (DATA_WIDTH),
         .DEPTH      (INPUT_BUFFER_DEPTH)
      ) u_fifo (
         .clk     (clk),
         .rst     (rst),
         .clr_i   (flush_i),
         .v_i     (bus.noc_ivalid[k]),
         .ready_o (ready_vec[k]),
         .data_i  (bus.noc_in[k*DATA_WIDTH +: DATA_WIDTH]),
         .v_o     (head_v[k]),
         .data_o  (ops_vec[k*DATA_WIDTH +: DATA_WIDTH]),
         .yumi_i  (yumi[k]),
         .count_o (count_o[k*CW +: CW])
      );
   end

   // Unused channels count as satisfied; an all-unused config never fires.
   assign ops_valid = (|cfg_used_i) && ((head_v | ~cfg_used_i) == {N{1'b1}});
   assign fire_ok   = bus.fire_i & ops_valid;
   assign yumi      = {N{fire_ok}} & cfg_used_i & ~cfg_sticky_i;

   assign bus.ops_valid_o = ops_valid;
   assign bus.ops_o       = ops_vec;
   assign bus.noc_oready  = ready_vec;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                              protocol_err_o <= 1'b0;
      else if (flush_i)                     protocol_err_o <= 1'b0;
      else if (bus.fire_i && !ops_valid)    protocol_err_o <= 1'b1;
   end
endmodule

// File: tb/tb_ucore_input_channels_multi.sv
// Bench for ucore_input_channels_multi: depth-2 and depth-3 instances share stimulus, checked against queue models.
module tb_ucore_input_channels_multi;
   localparam int N  = 2;
   localparam int DW = 32;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  cfg_used, cfg_sticky;
   logic        flush;
   logic [1:0]  ivalid;
   logic [63:0] din;
   logic        fire;
   logic [3:0]  cnt2, cnt3;
   logic        err2, err3;

   always #5 clk = ~clk;

   ucore_input_channels_multi_if #(.N(N), .DATA_WIDTH(DW)) bus2 ();
   ucore_input_channels_multi_if #(.N(N), .DATA_WIDTH(DW)) bus3 ();

   assign bus2.noc_ivalid = ivalid;
   assign bus2.noc_in     = din;
   assign bus2.fire_i     = fire;
   assign bus3.noc_ivalid = ivalid;
   assign bus3.noc_in     = din;
   assign bus3.fire_i     = fire;

   ucore_input_channels_multi #(.DATA_WIDTH(DW), .N(N), .INPUT_BUFFER_DEPTH(2)) dut (
      .clk(clk), .rst(rst), .cfg_used_i(cfg_used), .cfg_sticky_i(cfg_sticky),
      .flush_i(flush), .bus(bus2), .count_o(cnt2), .protocol_err_o(err2));

   ucore_input_channels_multi #(.DATA_WIDTH(DW), .N(N), .INPUT_BUFFER_DEPTH(3)) dut3 (
      .clk(clk), .rst(rst), .cfg_used_i(cfg_used), .cfg_sticky_i(cfg_sticky),
      .flush_i(flush), .bus(bus3), .count_o(cnt3), .protocol_err_o(err3));

   // Reference model: one token queue per (instance, channel).
   logic [31:0] mq [2][2][$];
   bit          merr [2];
   int          checks = 0;
   int          errors = 0;

   function automatic int depth_of(input int d);
      return (d == 0) ? 2 : 3;
   endfunction

   function automatic bit model_valid(input int d);
      bit v;
      v = (cfg_used != 2'b00);
      for (int k = 0; k < N; k++)
         if (cfg_used[k] && mq[d][k].size() == 0) v = 1'b0;
      return v;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         for (int k = 0; k < N; k++) mq[d][k].delete();
         merr[d] = 1'b0;
      end
   endtask

   task automatic check_model();
      for (int d = 0; d < 2; d++) begin
         logic [1:0]  er;
         logic [63:0] eo;
         logic [3:0]  ec;
         for (int k = 0; k < N; k++) begin
            er[k]          = (mq[d][k].size() < depth_of(d));
            eo[k*32 +: 32] = (mq[d][k].size() != 0) ? mq[d][k][0] : 32'h0;
            ec[k*2 +: 2]   = 2'(mq[d][k].size());
         end
         chk($sformatf("d%0d_ready", depth_of(d)), (d == 0) ? 64'(bus2.noc_oready) : 64'(bus3.noc_oready), 64'(er));
         chk($sformatf("d%0d_valid", depth_of(d)), (d == 0) ? 64'(bus2.ops_valid_o) : 64'(bus3.ops_valid_o), 64'(model_valid(d)));
         chk($sformatf("d%0d_ops", depth_of(d)), (d == 0) ? bus2.ops_o : bus3.ops_o, eo);
         chk($sformatf("d%0d_count", depth_of(d)), (d == 0) ? 64'(cnt2) : 64'(cnt3), 64'(ec));
         chk($sformatf("d%0d_err", depth_of(d)), (d == 0) ? 64'(err2) : 64'(err3), 64'(merr[d]));
      end
   endtask

   task automatic model_step();
      for (int d = 0; d < 2; d++) begin
         bit v;
         v = model_valid(d);
         if (flush) begin
            for (int k = 0; k < N; k++) mq[d][k].delete();
            merr[d] = 1'b0;
         end else begin
            if (fire && !v) merr[d] = 1'b1;
            for (int k = 0; k < N; k++) begin
               int pre;
               pre = mq[d][k].size();
               if (fire && v && cfg_used[k] && !cfg_sticky[k]) void'(mq[d][k].pop_front());
               if (ivalid[k] && pre < depth_of(d)) mq[d][k].push_back(din[k*32 +: 32]);
            end
         end
      end
   endtask

   // Check outputs, advance the model, and move to the next falling edge.
   task automatic cyc();
      #1;
      check_model();
      model_step();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      int  tok, nexp;
      bit  accepted;
      rst = 1'b1; cfg_used = 2'b11; cfg_sticky = 2'b00; flush = 1'b0;
      ivalid = 2'b00; din = '0; fire = 1'b0;
      model_reset();
      @(negedge clk); @(negedge clk);
      #1;
      chk("rst_ready", 64'(bus2.noc_oready), 64'h3);
      chk("rst_valid", 64'(bus2.ops_valid_o), 64'h0);
      chk("rst_ops", bus2.ops_o, 64'h0);
      chk("rst_count", 64'(cnt2), 64'h0);
      chk("rst_err", 64'(err2), 64'h0);
      rst = 1'b0;
      @(negedge clk);

      // Aligned enqueue on both channels, then fire.
      ivalid = 2'b11; din = {32'hB, 32'hA};
      cyc();
      ivalid = 2'b00;
      #1;
      chk("t1_valid", 64'(bus2.ops_valid_o), 64'h1);
      chk("t1_ops", bus2.ops_o, {32'hB, 32'hA});
      fire = 1'b1;
      cyc();
      fire = 1'b0;
      #1;
      chk("t1_count", 64'(cnt2), 64'h0);

      // Backpressure on a full depth-2 channel.
      ivalid = 2'b01; din = {32'h0, 32'h1}; cyc();
      din = {32'h0, 32'h2}; cyc();
      #1;
      chk("t2_count_full", 64'(cnt2[1:0]), 64'h2);
      chk("t2_ready_low", 64'(bus2.noc_oready[0]), 64'h0);
      din = {32'h0, 32'h3}; cyc();
      ivalid = 2'b10; din = {32'h7, 32'h0}; cyc();
      ivalid = 2'b00; fire = 1'b1; cyc();
      fire = 1'b0;
      #1;
      chk("t2_ready_back", 64'(bus2.noc_oready[0]), 64'h1);
      chk("t2_head", 64'(bus2.ops_o[31:0]), 64'h2);

      // Sticky operand on ch0.
      flush = 1'b1; cfg_used = 2'b11; cfg_sticky = 2'b01; cyc();
      flush = 1'b0;
      ivalid = 2'b01; din = {32'h0, 32'h5}; cyc();
      for (int i = 0; i < 3; i++) begin
         ivalid = 2'b10; din = {32'(32'h10 + i), 32'h0}; cyc();
         ivalid = 2'b00;
         #1;
         chk("t3_sticky_lane0", 64'(bus2.ops_o[31:0]), 64'h5);
         chk("t3_lane1", 64'(bus2.ops_o[63:32]), 64'(32'h10 + i));
         fire = 1'b1; cyc();
         fire = 1'b0;
      end
      #1;
      chk("t3_counts", 64'(cnt2), 64'h1);
      cfg_sticky = 2'b00;
      ivalid = 2'b10; din = {32'h20, 32'h0}; cyc();
      ivalid = 2'b00; fire = 1'b1; cyc();
      fire = 1'b0;
      #1;
      chk("t3_unstick", 64'(cnt2), 64'h0);

      // Depth-3 wrap: seven tokens on ch0, fire every other cycle.
      flush = 1'b1; cfg_used = 2'b01; cfg_sticky = 2'b00; cyc();
      flush = 1'b0;
      tok = 0; nexp = 0;
      for (int i = 0; i < 22; i++) begin
         ivalid = (tok < 7) ? 2'b01 : 2'b00;
         din = {32'h0, 32'(32'h100 + tok)};
         fire = i[0];
         #1;
         if (fire && bus3.ops_valid_o) begin
            chk("t4_order", 64'(bus3.ops_o[31:0]), 64'(32'h100 + nexp));
            nexp++;
         end
         accepted = (tok < 7) && bus3.noc_oready[0];
         cyc();
         if (accepted) tok++;
      end
      fire = 1'b0; ivalid = 2'b00;
      chk("t4_drained", 64'(nexp), 64'd7);

      // Protocol error then flush with concurrent enqueue.
      flush = 1'b1; cfg_used = 2'b11; cyc();
      flush = 1'b0;
      ivalid = 2'b01; din = {32'h0, 32'h33}; cyc();
      ivalid = 2'b00; fire = 1'b1; cyc();
      fire = 1'b0;
      #1;
      chk("t5_err_set", 64'(err2), 64'h1);
      chk("t5_count_kept", 64'(cnt2), 64'h1);
      flush = 1'b1; ivalid = 2'b11; din = {32'h44, 32'h55}; cyc();
      flush = 1'b0; ivalid = 2'b00;
      #1;
      chk("t5_flush_count", 64'(cnt2), 64'h0);
      chk("t5_flush_err", 64'(err2), 64'h0);

      // Asynchronous reset between clock edges.
      ivalid = 2'b11; din = {32'h31, 32'h21}; cyc();
      ivalid = 2'b01; din = {32'h0, 32'h22}; cyc();
      ivalid = 2'b00;
      #2 rst = 1'b1;
      #1;
      chk("t6_ready", 64'(bus2.noc_oready), 64'h3);
      chk("t6_valid", 64'(bus2.ops_valid_o), 64'h0);
      chk("t6_ops", bus2.ops_o, 64'h0);
      chk("t6_count", 64'(cnt2), 64'h0);
      chk("t6_count3", 64'(cnt3), 64'h0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      ivalid = 2'b11; din = {32'h88, 32'h77}; cyc();
      ivalid = 2'b00;
      #1;
      chk("t6_head", bus2.ops_o, {32'h88, 32'h77});

      // Randomized traffic; config only changes alongside a flush.
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(15) == 0) begin
            flush = 1'b1;
            cfg_used = 2'($urandom);
            cfg_sticky = 2'($urandom);
         end else begin
            flush = 1'b0;
         end
         ivalid = 2'($urandom);
         din = {$urandom(), $urandom()};
         fire = ($urandom_range(2) != 0);
         cyc();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
